// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller and segment decoder.
package ssd_pkg;

  localparam logic [3:0] CODE_ADD   = 4'd10;
  localparam logic [3:0] CODE_SUB   = 4'd11;
  localparam logic [3:0] CODE_MUL   = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] an_pattern(input digit_idx_t idx);
    logic [3:0] an;
    unique case (idx)
      2'd0:    an = AN_DIG0;
      2'd1:    an = AN_DIG1;
      2'd2:    an = AN_DIG2;
      default: an = AN_DIG3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Prescaler: one-cycle tick every SCAN_DIV clocks, counting 0..SCAN_DIV-1.
module ssd_tick_gen #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed display scanner with tear-free frame update and
// optional leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  output logic [3:0]  ssd_in,
  output logic [3:0]  ssd_an,
  output logic        pending,
  output logic        load_ack
);

  logic        tick;
  logic        apply;
  digit_idx_t  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] display_q, display_d;
  logic        pending_q, pending_d;
  logic        load_ack_q;
  logic [3:0]  ssd_in_q, ssd_in_d;
  logic [3:0]  ssd_an_q, ssd_an_d;
  logic [3:0]  code;
  logic        upper_zero;

  ssd_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // New data lands only on the 3->0 wrap so a frame never mixes old and new digits.
  always_comb begin
    apply     = tick && (idx_q == 2'd3) && pending_q;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    display_d = apply ? shadow_q : display_q;
    shadow_d  = load ? digits_in : shadow_q;
    pending_d = load || (pending_q && !apply);
  end

  // Outputs are computed from next-state so they follow idx with one cycle latency.
  always_comb begin
    code       = display_d[3:0];
    upper_zero = 1'b0;
    unique case (idx_d)
      2'd0: begin
        code       = display_d[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        code       = display_d[7:4];
        upper_zero = (display_d[15:4] == 12'h000);
      end
      2'd2: begin
        code       = display_d[11:8];
        upper_zero = (display_d[15:8] == 8'h00);
      end
      default: begin
        code       = display_d[15:12];
        upper_zero = (display_d[15:12] == 4'h0);
      end
    endcase
    ssd_in_d = (blank_lz && upper_zero) ? CODE_BLANK : code;
    ssd_an_d = an_pattern(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 2'd0;
      shadow_q   <= '0;
      display_q  <= '0;
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
      ssd_in_q   <= 4'd0;
      ssd_an_q   <= AN_DIG0;
    end else begin
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      display_q  <= display_d;
      pending_q  <= pending_d;
      load_ack_q <= apply;
      ssd_in_q   <= ssd_in_d;
      ssd_an_q   <= ssd_an_d;
    end
  end

  assign ssd_in   = ssd_in_q;
  assign ssd_an   = ssd_an_q;
  assign pending  = pending_q;
  assign load_ack = load_ack_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised and directed bench for ssd_scan_ctrl against a frame-level model.
module tb_ssd_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  ssd_in;
  logic [3:0]  ssd_an;
  logic        pending;
  logic        load_ack;

  int passed = 0;
  int total  = 0;

  // Model state: edges since reset release, captured and shown words.
  int          t;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  logic        m_pend;
  logic [3:0]  e_in;
  logic [3:0]  e_an;
  logic        e_pend;
  logic        e_ack;
  int          acks;

  ssd_scan_ctrl #(
    .SCAN_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .digits_in(digits_in),
    .blank_lz (blank_lz),
    .ssd_in   (ssd_in),
    .ssd_an   (ssd_an),
    .pending  (pending),
    .load_ack (load_ack)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    t        = 0;
    m_shadow = 16'h0;
    m_disp   = 16'h0;
    m_pend   = 1'b0;
    e_ack    = 1'b0;
  endtask

  // One clock: advance the model on the rising edge, return at the falling edge.
  task automatic cyc();
    int  idx;
    bit  wrap;
    @(posedge clk);
    wrap  = (t % DIV == DIV - 1) && ((t / DIV) % 4 == 3);
    e_ack = 1'b0;
    if (wrap && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
      e_ack  = 1'b1;
      acks++;
    end
    if (load) begin
      m_shadow = digits_in;
      m_pend   = 1'b1;
    end
    t++;
    idx    = (t / DIV) % 4;
    e_an   = 4'hF ^ (4'h1 << idx);
    e_in   = m_disp[4*idx +: 4];
    if (blank_lz && idx > 0 && (m_disp >> (4 * idx)) == 16'h0) e_in = 4'hF;
    e_pend = m_pend;
    @(negedge clk);
  endtask

  function automatic bit at_wrap_edge();
    return (t % DIV == DIV - 1) && ((t / DIV) % 4 == 3);
  endfunction

  task automatic test_reset();
    load = 1'b1; digits_in = 16'h4321;
    cyc();
    load = 1'b0;
    repeat (9) begin
      cyc();
      total++;
      if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
        $display("FAIL reset_pre t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                 t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
      else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ssd_an !== 4'b1110) $display("FAIL reset_an got %b want 1110", ssd_an);
    else passed++;
    total++;
    if (ssd_in !== 4'd0) $display("FAIL reset_in got %0d want 0", ssd_in);
    else passed++;
    total++;
    if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending);
    else passed++;
    total++;
    if (load_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", load_ack);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_scan();
    repeat (32) begin
      cyc();
      total++;
      if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
        $display("FAIL scan t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                 t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
      else passed++;
    end
  endtask

  task automatic test_load();
    int a0;
    for (int i = 0; i < 16 && ((t / DIV) % 4 != 1); i++) cyc();
    load = 1'b1; digits_in = 16'h1A23;
    a0 = acks;
    cyc();
    load = 1'b0;
    repeat (40) begin
      cyc();
      total++;
      if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
        $display("FAIL load t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                 t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
      else passed++;
    end
    total++;
    if (acks - a0 != 1) $display("FAIL load_ack_count got %0d want 1", acks - a0);
    else passed++;
  endtask

  task automatic test_last_wins();
    int a0;
    for (int i = 0; i < 16 && ((t / DIV) % 4 != 0); i++) cyc();
    a0 = acks;
    load = 1'b1; digits_in = 16'h1111;
    cyc();
    load = 1'b0;
    cyc();
    load = 1'b1; digits_in = 16'h2222;
    cyc();
    load = 1'b0;
    repeat (36) begin
      cyc();
      total++;
      if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
        $display("FAIL last_wins t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                 t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
      else passed++;
    end
    total++;
    if (acks - a0 != 1) $display("FAIL last_wins_ack_count got %0d want 1", acks - a0);
    else passed++;
  endtask

  task automatic test_blanking();
    logic [15:0] pat [3] = '{16'h0050, 16'h0050, 16'h0000};
    logic        blk [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      blank_lz = blk[k];
      load = 1'b1; digits_in = pat[k];
      cyc();
      load = 1'b0;
      repeat (36) begin
        cyc();
        total++;
        if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
          $display("FAIL blank%0d t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                   k, t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
        else passed++;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_coincident();
    int a0;
    a0 = acks;
    load = 1'b1; digits_in = 16'h3456;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 64 && !at_wrap_edge(); i++) cyc();
    load = 1'b1; digits_in = 16'h789A;
    cyc();
    load = 1'b0;
    total++;
    if ({pending, load_ack} !== 2'b11 || {e_pend, e_ack} !== 2'b11)
      $display("FAIL coincident_edge got pend=%b ack=%b want pend=1 ack=1 (model %b%b)",
               pending, load_ack, e_pend, e_ack);
    else passed++;
    repeat (40) begin
      cyc();
      total++;
      if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
        $display("FAIL coincident t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                 t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
      else passed++;
    end
    total++;
    if (acks - a0 != 2) $display("FAIL coincident_ack_count got %0d want 2", acks - a0);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] d;
    repeat (400) begin
      load     = ($urandom_range(0, 5) == 0);
      blank_lz = $urandom_range(0, 1);
      d        = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) d[4*k +: 4] = 4'h0;
      digits_in = d;
      cyc();
      total++;
      if ({ssd_an, ssd_in, pending, load_ack} !== {e_an, e_in, e_pend, e_ack})
        $display("FAIL random t=%0d got an=%b in=%0d pend=%b ack=%b want an=%b in=%0d pend=%b ack=%b",
                 t, ssd_an, ssd_in, pending, load_ack, e_an, e_in, e_pend, e_ack);
      else passed++;
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    acks = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_scan();
    test_load();
    test_last_wins();
    test_blanking();
    test_coincident();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles each digit is shown (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load  input  1  one-cycle request to capture digits_in.
REQ-005 SHALL have port digits_in  input  16  four 4-bit codes; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-006 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled every cycle.
REQ-007 SHALL have port ssd_in  output  4  code for the segment decoder (0-9, 10=A, 11=S, 12=M, 15=blank).
REQ-008 SHALL have port ssd_an  output  4  digit enables, active-low one-hot.
REQ-009 SHALL have port pending  output  1  high while captured data awaits application.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when captured data reaches the display.

Function
REQ-011 SHALL keep a prescale counter 0..SCAN_DIV-1; tick = (count == SCAN_DIV-1); count wraps to 0 on tick.
REQ-012 SHALL keep digit index idx 0..3, advancing idx+1 mod 4 on each tick.
REQ-013 SHALL register ssd_in/ssd_an; in the cycle after a tick they reflect the new idx (1-cycle latency).
REQ-014 SHALL drive ssd_an: idx0=1110, idx1=1101, idx2=1011, idx3=0111; never more than one bit low.
REQ-015 SHALL capture digits_in into a shadow register on load and set pending=1.
REQ-016 SHALL overwrite the shadow on a second load before application (last-wins); no ack for the dropped value.
REQ-017 SHALL copy shadow to the display register only on the tick where idx wraps 3->0 with pending=1 (tear-free frame), clear pending, pulse load_ack for exactly that cycle.
REQ-018 SHALL, on load coincident with an applying tick, apply the old shadow, capture the new data, keep pending=1, pulse load_ack.
REQ-019 SHALL, with blank_lz=1, output code 15 for digits 3..1 whose code is 0 and all higher digits are 0.
REQ-020 SHALL never blank digit 0; codes 10-12 count as non-zero for blanking.
REQ-021 SHALL pass codes 13-15 through unchanged (decoder shows them blank).
REQ-022 SHALL leave the display register unchanged when no load is pending.

Reset
REQ-023 SHALL, while rst_n=0, immediately force count=0, idx=0, shadow=0, display=0, pending=0, load_ack=0, ssd_in=0, ssd_an=1110.
REQ-024 SHALL discard any pending load on reset mid-operation; first tick after release occurs SCAN_DIV cycles later.

Structure
REQ-025 SHALL import constants from shared package ssd_pkg: CODE_ADD=10, CODE_SUB=11, CODE_MUL=12, CODE_BLANK=15, four anode patterns; the segment decoder uses the same package.
REQ-026 SHALL instantiate one sub-module ssd_tick_gen (parameter SCAN_DIV; ports clk, rst_n, tick) for the prescaler.
REQ-027 SHALL size the counter as $clog2(SCAN_DIV).

Verification (SCAN_DIV=4)
REQ-028 SHALL check reset: rst_n low mid-scan -> next edge-independent ssd_an=1110, ssd_in=0, pending=0.
REQ-029 SHALL check scan: no load, 16 cycles -> ssd_an sequence 1110,1101,1011,0111 each held 4 cycles, repeating.
REQ-030 SHALL check load: digits_in=16'h1A23 at idx1 -> pending=1 until idx3->0 tick, load_ack single pulse, then ssd_in 3,2,10,1 by idx.
REQ-031 SHALL check last-wins: loads 16'h1111 then 16'h2222 in one frame -> one ack, display shows 2 on all digits.
REQ-032 SHALL check blanking: digits_in=16'h0050, blank_lz=1 -> ssd_in 0,5,15,15; with blank_lz=0 -> 0,5,0,0; 16'h0000 -> 0,15,15,15.
REQ-033 SHALL check coincident load on applying tick -> old data displayed, pending stays 1, new data applied one frame later with a second ack.
